// File: rtl/booth_issue.sv
// rtl/booth_issue.sv - operand issue and product capture front-end for the 16-bit Booth multiplier
// Optional SEND_Q abort path enabled by defining BOOTH_ISSUE_TIMEOUT_EN.
module booth_issue #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_m,
  input  logic [W-1:0]   in_q,
  output logic           mul_start,
  output logic [W-1:0]   mul_data,
  input  logic           mul_done,
  input  logic [W-1:0]   mul_a,
  input  logic [W-1:0]   mul_q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           busy,
  output logic           err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_M = 3'd1,
    HOLD_M = 3'd2,
    SEND_Q = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   buf_m;
  logic [W-1:0]   buf_q;
  logic           buf_vld;
  logic [W-1:0]   cur_m;
  logic [W-1:0]   cur_q;
  logic           accept;
  logic           drain;
  logic           capture;
  logic [2*W-1:0] capture_val;
  logic           tmo_hit;

  assign in_ready = !buf_vld;
  assign accept   = in_valid && in_ready;

`ifdef BOOTH_ISSUE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // Counter is held at zero outside SEND_Q, so every SEND_Q entry starts a fresh window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state != SEND_Q) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign tmo_hit = (state == SEND_Q) && !mul_done && (tmo_cnt == CW'(TIMEOUT - 1));
  assign err     = err_q;
`else
  // Without the abort path SEND_Q waits on mul_done indefinitely; TIMEOUT has no effect.
  assign tmo_hit = 1'b0 & (TIMEOUT > 0);
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    drain       = 1'b0;
    capture     = 1'b0;
    capture_val = {mul_a, mul_q};
    mul_start   = 1'b0;
    mul_data    = '0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (buf_vld) begin
          drain     = 1'b1;
          state_nxt = SEND_M;
        end
      end
      SEND_M: begin
        mul_start = 1'b1;
        mul_data  = cur_m;
        state_nxt = HOLD_M;
      end
      HOLD_M: begin
        mul_data  = cur_m;
        state_nxt = SEND_Q;
      end
      SEND_Q: begin
        mul_data = cur_q;
        if (mul_done) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end else if (tmo_hit) begin
          capture     = 1'b1;
          capture_val = '0;
          state_nxt   = RESULT;
        end
      end
      RESULT: begin
        out_valid = 1'b1;
        mul_data  = cur_q;
        // A waiting pair issues straight from RESULT so back-to-back products skip IDLE.
        if (out_ready) begin
          if (buf_vld) begin
            drain     = 1'b1;
            state_nxt = SEND_M;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld <= 1'b0;
      buf_m   <= '0;
      buf_q   <= '0;
    end else begin
      if (accept) begin
        buf_m <= in_m;
        buf_q <= in_q;
      end
      buf_vld <= accept || (buf_vld && !drain);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_m <= '0;
      cur_q <= '0;
    end else if (drain) begin
      cur_m <= buf_m;
      cur_q <= buf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result <= '0;
    end else if (capture) begin
      out_result <= capture_val;
    end
  end

endmodule
